// File: rtl/mx_shared_exp_ctrl.sv
// MX shared-exponent controller: collects one block of element exponents,
// tracks the block maximum, then streams per-element shift amounts.
module mx_shared_exp_ctrl #(
    parameter  int BLOCK_SIZE = 8,
    parameter  int EXP_W      = 5,
    localparam int IDX_W      = $clog2(BLOCK_SIZE)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_shared_exp,
    output logic [EXP_W-1:0] out_shift,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [EXP_W-1:0] max_q, max_d;
    logic             ready_q;
    logic [EXP_W-1:0] buf_q [BLOCK_SIZE];

    logic             in_acc;
    logic             max_ge;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready/out_valid never depend combinationally on the
    // partner's valid/ready.
    assign in_acc = in_valid && in_ready;
    assign max_ge = (max_q >= in_exp);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= COLLECT;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            max_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            max_q    <= max_d;
            ready_q  <= 1'b1;
        end
    end

    // Buffer is never reset; outputs only read it after a full block is written.
    always_ff @(posedge CLK) begin
        if (in_acc && !clear) begin
            buf_q[wr_idx_q] <= in_exp;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        max_d    = max_q;
        if (clear) begin
            state_d  = COLLECT;
            wr_idx_d = '0;
            rd_idx_d = '0;
            max_d    = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_acc) begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        if ((wr_idx_q == '0) || !max_ge) begin
                            max_d = in_exp;
                        end
                        if (wr_idx_q == LAST_IDX) begin
                            state_d  = EMIT;
                            wr_idx_d = '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_d  = COLLECT;
                            rd_idx_d = '0;
                            max_d    = '0;
                        end else begin
                            rd_idx_d = rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready       = (state_q == COLLECT) && ready_q;
        out_valid      = 1'b0;
        busy           = 1'b0;
        out_shared_exp = '0;
        out_shift      = '0;
        out_idx        = '0;
        out_last       = 1'b0;
        if (state_q == EMIT) begin
            out_valid      = 1'b1;
            busy           = 1'b1;
            out_shared_exp = max_q;
            out_shift      = max_q - buf_q[rd_idx_q];
            out_idx        = rd_idx_q;
            out_last       = (rd_idx_q == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_mx_shared_exp_ctrl.sv
// Bench for mx_shared_exp_ctrl: directed vector table, multi-cycle corner
// sequences and random blocks checked against a max/subtract reference model.
module tb_mx_shared_exp_ctrl;

    localparam int BS  = 8;
    localparam int EW  = 5;
    localparam int IW  = 3;
    localparam int SBW = EW + EW + IW + 1;

    logic          CLK;
    logic          RSTN;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_shared_exp;
    logic [EW-1:0] out_shift;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    mx_shared_exp_ctrl #(.BLOCK_SIZE(BS), .EXP_W(EW)) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_exp         (in_exp),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_shared_exp (out_shared_exp),
        .out_shift      (out_shift),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .busy           (busy)
    );

    typedef struct {
        logic [EW-1:0] exps   [BS];
        logic [EW-1:0] shared;
        logic [EW-1:0] shifts [BS];
        int            gap;
    } vec_t;

    vec_t           vecs [5];
    logic [SBW-1:0] exp_q [$];
    int             n_pass;
    int             n_total;

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every output handshake must match the head of exp_q.
    always @(negedge CLK) begin
        if (RSTN && out_valid && out_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL spurious_out: got idx %0d with empty expectation queue", out_idx);
            end else begin
                logic [SBW-1:0] e;
                logic [SBW-1:0] a;
                e = exp_q.pop_front();
                a = {out_shared_exp, out_shift, out_idx, out_last};
                if (a === e && busy === 1'b1) n_pass++;
                else $display("FAIL out_elem: got shared %0d shift %0d idx %0d last %0d busy %0d, expected shared %0d shift %0d idx %0d last %0d busy 1",
                              out_shared_exp, out_shift, out_idx, out_last, busy,
                              e[SBW-1 -: EW], e[IW+EW : IW+1], e[IW:1], e[0]);
            end
        end
    end

    // Reference model: shared exponent is the block maximum, shift = max - element.
    task automatic model_block(input logic [EW-1:0] e [BS]);
        int m;
        m = 0;
        foreach (e[i]) if (int'(e[i]) > m) m = int'(e[i]);
        for (int i = 0; i < BS; i++) begin
            exp_q.push_back({EW'(m), EW'(m - int'(e[i])), IW'(i), (i == BS - 1)});
        end
    endtask

    task automatic table_expect(input vec_t v);
        for (int i = 0; i < BS; i++) begin
            exp_q.push_back({v.shared, v.shifts[i], IW'(i), (i == BS - 1)});
        end
    endtask

    // Driver: present one exponent (after an optional idle gap) until accepted.
    task automatic push(input logic [EW-1:0] e, input int gap);
        int  waits;
        bit  r;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_exp   = EW'($urandom);
            @(posedge CLK); #1;
        end
        in_valid = 1'b1;
        in_exp   = e;
        waits    = 0;
        do begin
            @(negedge CLK);
            r = in_ready;
            @(posedge CLK); #1;
            waits++;
        end while (!r && waits < 50);
        if (!r) check("push_timeout", 32'(r), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [EW-1:0] e [BS], input int gap_max);
        for (int i = 0; i < BS; i++) begin
            if (i == BS - 1) check("pre_last_out_valid", 32'(out_valid), 32'd0);
            push(e[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
        end
        check("out_valid_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input bit rand_rdy);
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 300) begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK); #1;
            cnt++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        check("post_block_in_ready", 32'(in_ready), 32'd1);
        check("post_block_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [EW-1:0] blk [BS];
        n_pass    = 0;
        n_total   = 0;
        RSTN      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        out_ready = 1'b1;

        vecs[0].exps = '{5'd3, 5'd7, 5'd1, 5'd7, 5'd0, 5'd2, 5'd5, 5'd4};
        vecs[0].shared = 5'd7;
        vecs[0].shifts = '{5'd4, 5'd0, 5'd6, 5'd0, 5'd7, 5'd5, 5'd2, 5'd3};
        vecs[0].gap = 0;
        vecs[1].exps = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        vecs[1].shared = 5'd0;
        vecs[1].shifts = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        vecs[1].gap = 0;
        vecs[2].exps = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        vecs[2].shared = 5'd31;
        vecs[2].shifts = '{5'd0, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
        vecs[2].gap = 0;
        vecs[3] = vecs[0];
        vecs[3].gap = 4;
        vecs[4].exps = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        vecs[4].shared = 5'd8;
        vecs[4].shifts = '{5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        vecs[4].gap = 0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fields", 32'({out_shared_exp, out_shift, out_idx, out_last}), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK); #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            table_expect(vecs[v]);
            send_block(vecs[v].exps, vecs[v].gap);
            drain(1'b0);
        end

        // Backpressure: stall three cycles at idx 2 while in_valid pulses.
        out_ready = 1'b0;
        model_block(vecs[0].exps);
        send_block(vecs[0].exps, 0);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_exp   = 5'd30;
            @(negedge CLK);
            check("stall_idx", 32'(out_idx), 32'd2);
            check("stall_shared", 32'(out_shared_exp), 32'd7);
            check("stall_shift", 32'(out_shift), 32'd6);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        drain(1'b0);
        table_expect(vecs[4]);
        send_block(vecs[4].exps, 0);
        drain(1'b0);

        // Clear during EMIT at idx 4 with out_ready high.
        out_ready = 1'b1;
        model_block(vecs[0].exps);
        send_block(vecs[0].exps, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
        end
        clear = 1'b1;
        @(negedge CLK);
        check("clear_at_idx", 32'(out_idx), 32'd4);
        @(posedge CLK); #1;
        clear = 1'b0;
        exp_q.delete();
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_in_ready", 32'(in_ready), 32'd1);
        check("clear_busy", 32'(busy), 32'd0);
        table_expect(vecs[4]);
        send_block(vecs[4].exps, 0);
        drain(1'b0);

        // Reset after five accepts of large exponents.
        for (int i = 0; i < 5; i++) push(5'd30 + 5'(i % 2), 0);
        RSTN = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fields", 32'({out_shared_exp, out_shift, out_idx, out_last}), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < BS; i++) blk[i] = EW'($urandom_range(0, 10));
        model_block(blk);
        send_block(blk, 0);
        drain(1'b0);

        // Random blocks with input gaps and random output backpressure.
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < BS; i++) blk[i] = EW'($urandom);
            model_block(blk);
            send_block(blk, 3);
            drain(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mx_shared_exp_ctrl.md
MX_SHARED_EXP_CTRL -- requirements
Module: mx_shared_exp_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 8, number of elements per MX block (power of two, >= 2).
REQ-002 SHALL have parameter EXP_W, default 5, element exponent width.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous abort of the current block.
REQ-006 SHALL have port in_valid  input  1  in_exp carries a valid element exponent.
REQ-007 SHALL have port in_ready  output  1  block accepts an exponent this cycle.
REQ-008 SHALL have port in_exp  input  EXP_W  unsigned element exponent.
REQ-009 SHALL have port out_valid  output  1  out_* fields valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output this cycle.
REQ-011 SHALL have port out_shared_exp  output  EXP_W  block maximum exponent.
REQ-012 SHALL have port out_shift  output  EXP_W  out_shared_exp minus the element exponent.
REQ-013 SHALL have port out_idx  output  log2(BLOCK_SIZE)  element index, arrival order.
REQ-014 SHALL have port out_last  output  1  high with the element of index BLOCK_SIZE-1.
REQ-015 SHALL have port busy  output  1  high while in EMIT.

Function
REQ-016 SHALL implement a two-state FSM: COLLECT (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-017 SHALL, in COLLECT, accept on in_valid&&in_ready, store in_exp into buffer[wr_idx] and increment wr_idx.
REQ-018 SHALL maintain a running max with one unsigned >= comparator: the first element of a block loads max unconditionally; later elements replace max only if strictly greater.
REQ-019 SHALL move to EMIT on the edge accepting element BLOCK_SIZE-1; out_valid SHALL be high the following cycle (1-cycle latency from last accept).
REQ-020 SHALL, in EMIT, drive out_shared_exp=max, out_idx=rd_idx, out_shift=max-buffer[rd_idx] (never negative, no saturation needed), out_last=(rd_idx==BLOCK_SIZE-1).
REQ-021 SHALL hold all out_* stable while out_valid&&!out_ready.
REQ-022 SHALL advance rd_idx on out_valid&&out_ready; on the handshake with out_last=1 it SHALL return to COLLECT, zero wr_idx/rd_idx/max, and assert in_ready the next cycle.
REQ-023 SHALL ignore in_valid while in EMIT (no overlap of consecutive blocks).
REQ-024 SHALL, on clear=1, go to COLLECT with wr_idx=rd_idx=max=0 the next cycle, regardless of state; clear SHALL take priority over a simultaneous input or output handshake, which is then discarded.
REQ-025 SHALL tolerate in_valid gaps of any length in COLLECT without changing state or max.
REQ-026 SHALL assert busy exactly when state is EMIT.

Reset
REQ-027 SHALL, while RSTN=0, force state=COLLECT, wr_idx=rd_idx=0, max=0, out_valid=0, busy=0, out_shared_exp=out_shift=out_idx=out_last=0; in_ready=1 from the first edge after release.
REQ-028 SHALL not require buffer contents to be reset; no buffer value SHALL be visible on outputs before being written in the current block.
REQ-029 SHALL abandon a partially collected or partially emitted block on reset assertion.

Verification (BLOCK_SIZE=8, EXP_W=5)
REQ-030 SHALL cover: exps 3,7,1,7,0,2,5,4 back-to-back, out_ready=1 -> shared 7, shifts 4,0,6,0,7,5,2,3, idx 0..7, out_last only on idx 7, out_valid one cycle after last accept.
REQ-031 SHALL cover: all exps 0 -> shared 0, all shifts 0; then exps 31,0,0,0,0,0,0,0 -> shared 31, shifts 0,31,31,31,31,31,31,31.
REQ-032 SHALL cover: out_ready low 3 cycles at idx 2 -> out_idx=2, out_shift, out_shared_exp stable for all 3 cycles; in_valid pulses during EMIT not accepted.
REQ-033 SHALL cover: in_valid with random gaps during COLLECT -> same results as REQ-030.
REQ-034 SHALL cover: clear during EMIT at idx 4 with out_ready=1 -> next cycle out_valid=0, in_ready=1; following block 1,2,3,4,5,6,7,8 -> shared 8, shifts 7..0.
REQ-035 SHALL cover: RSTN low after 5 accepts -> outputs at reset values immediately; new full block afterwards yields correct max unaffected by prior data.
